// File: rtl/maxpool_stage.sv
// 2x2 stride-2 max-pool over a 64x64 Q4.16 map into a 32x32 map, each
// result rounded up to the next integer (ceiling) with positive saturation.
module maxpool_stage (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic        crd,
   output logic [11:0] caddr_rd,
   input  logic [19:0] cdata_rd,
   output logic        cwr,
   output logic [9:0]  caddr_wr,
   output logic [19:0] cdata_wr,
   output logic [2:0]  csel
);

   typedef enum logic [2:0] {IDLE, READ, LAST, WRITE, DONE} state_t;

   state_t      state;
   state_t      next_state;
   logic [9:0]  o;
   logic [1:0]  k;
   logic [19:0] max_val;
   logic [19:0] ceil_val;
   logic        greater;

   assign greater = $signed(cdata_rd) > $signed(max_val);

   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= next_state;
   end

   // Read data lags the strobe by one cycle, so element k-1 is folded in while k is issued.
   always_ff @(posedge clk) begin
      if (reset) begin
         o       <= 10'd0;
         k       <= 2'd0;
         max_val <= 20'd0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  o <= 10'd0;
                  k <= 2'd0;
               end
            end
            READ: begin
               k <= k + 2'd1;
               if (k == 2'd1)
                  max_val <= cdata_rd;
               else if (k != 2'd0 && greater)
                  max_val <= cdata_rd;
            end
            LAST: begin
               if (greater)
                  max_val <= cdata_rd;
            end
            WRITE: begin
               o <= o + 10'd1;
               k <= 2'd0;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start) next_state = READ;
         READ:    if (k == 2'd3) next_state = LAST;
         LAST:    next_state = WRITE;
         WRITE:   next_state = (o == 10'd1023) ? DONE : READ;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Adding one to the integer part of 7.x would wrap negative, so it clamps instead.
   always_comb begin
      ceil_val = max_val;
      if (max_val[15:0] != 16'h0) begin
         if (max_val[19:16] == 4'h7)
            ceil_val = 20'h7FFFF;
         else
            ceil_val = {max_val[19:16] + 4'd1, 16'h0};
      end
   end

   always_comb begin
      busy     = 1'b0;
      done     = 1'b0;
      crd      = 1'b0;
      cwr      = 1'b0;
      caddr_rd = 12'd0;
      caddr_wr = 10'd0;
      cdata_wr = 20'd0;
      csel     = 3'b000;
      case (state)
         READ: begin
            busy     = 1'b1;
            crd      = 1'b1;
            csel     = 3'b001;
            caddr_rd = {o[9:5], k[1], o[4:0], k[0]};
         end
         LAST: busy = 1'b1;
         WRITE: begin
            busy = 1'b1;
            if (!reset) begin
               cwr      = 1'b1;
               csel     = 3'b011;
               caddr_wr = o;
               cdata_wr = ceil_val;
            end
         end
         DONE: done = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_maxpool_stage.sv
// Scoreboard bench for maxpool_stage: a layer-0 memory model feeds the DUT,
// expected writes are queued at start and a monitor checks every write.
module tb_maxpool_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        busy;
   logic        done;
   logic        crd;
   logic [11:0] caddr_rd;
   logic [19:0] cdata_rd;
   logic        cwr;
   logic [9:0]  caddr_wr;
   logic [19:0] cdata_wr;
   logic [2:0]  csel;

   maxpool_stage dut (
      .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
      .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .cwr(cwr),
      .caddr_wr(caddr_wr), .cdata_wr(cdata_wr), .csel(csel)
   );

   always #5 clk = ~clk;

   logic [19:0] mem [0:4095];
   logic        hand_valid [0:1023];
   logic [19:0] hand_val [0:1023];
   logic [29:0] q [$];

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int frame_writes, done_cnt, last_rd_addr, first_rd_cycle, last_wr_cycle, last_wr_addr;
   bit first_rd_seen, wr_seen, prev_busy;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (crd) cdata_rd <= mem[caddr_rd];
   end

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int sx(input logic [19:0] x);
      return {{12{x[19]}}, x};
   endfunction

   function automatic logic [19:0] pool_ref(input int o);
      int base, m, c, r;
      base = (o / 32) * 128 + (o % 32) * 2;
      m = sx(mem[base]);
      if (sx(mem[base + 1]) > m) m = sx(mem[base + 1]);
      if (sx(mem[base + 64]) > m) m = sx(mem[base + 64]);
      if (sx(mem[base + 65]) > m) m = sx(mem[base + 65]);
      c = (m + 65535) >>> 16;
      r = c * 65536;
      if (r > 524287) r = 524287;
      return r[19:0];
   endfunction

   task automatic set_window(input int o, input logic [19:0] a, input logic [19:0] b,
                             input logic [19:0] c, input logic [19:0] d, input logic [19:0] e);
      int base;
      base = (o / 32) * 128 + (o % 32) * 2;
      mem[base] = a; mem[base + 1] = b; mem[base + 64] = c; mem[base + 65] = d;
      hand_valid[o] = 1'b1;
      hand_val[o] = e;
   endtask

   task automatic fill_random();
      for (int i = 0; i < 4096; i++) mem[i] = 20'($urandom);
      for (int i = 0; i < 1024; i++) hand_valid[i] = 1'b0;
   endtask

   // Monitor: protocol checks every cycle, scoreboard pop on every write.
   always @(negedge clk) begin
      logic [29:0] e;
      if (crd) begin
         check_output("csel_on_read", 32'(csel), 32'h1);
         check_output("rd_wr_overlap", 32'(cwr), 32'h0);
         last_rd_addr = caddr_rd;
         if (!first_rd_seen) begin
            first_rd_seen = 1'b1;
            first_rd_cycle = cyc;
         end
      end else if (!cwr && csel != 3'b000) begin
         check_output("csel_idle", 32'(csel), 32'h0);
      end
      if (cwr) begin
         check_output("csel_on_write", 32'(csel), 32'h3);
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_write: got addr %0d data %0h expected no write", caddr_wr, cdata_wr);
         end else begin
            e = q.pop_front();
            check_output($sformatf("wr_addr[%0d]", e[29:20]), 32'(caddr_wr), 32'(e[29:20]));
            check_output($sformatf("wr_data[%0d]", e[29:20]), 32'(cdata_wr), 32'(e[19:0]));
         end
         if (wr_seen) check_output("wr_spacing", 32'(cyc - last_wr_cycle), 32'd6);
         wr_seen = 1'b1;
         last_wr_cycle = cyc;
         last_wr_addr = caddr_wr;
         frame_writes++;
      end
      if (done) begin
         done_cnt++;
         check_output("busy_at_done", 32'(busy), 32'h0);
         check_output("busy_before_done", 32'(prev_busy), 32'h1);
      end
      prev_busy = busy;
   end

   task automatic clear_frame();
      frame_writes = 0; done_cnt = 0; last_rd_addr = -1; first_rd_cycle = 0;
      last_wr_cycle = 0; last_wr_addr = -1; first_rd_seen = 1'b0; wr_seen = 1'b0;
      q.delete();
      for (int o = 0; o < 1024; o++)
         q.push_back({10'(o), hand_valid[o] ? hand_val[o] : pool_ref(o)});
   endtask

   task automatic apply_stimulus();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      check_output("busy_after_start", 32'(busy), 32'h1);
   endtask

   task automatic run_frame(input bit repulse);
      bit got;
      got = 1'b0;
      clear_frame();
      apply_stimulus();
      for (int i = 0; i < 7000 && !got; i++) begin
         @(negedge clk);
         if (repulse) start = (i == 100 || i == 3000);
         if (done) got = 1'b1;
      end
      start = 1'b0;
      if (!got) begin
         total++;
         bad++;
         $display("[TB] FAIL frame_timeout: got no done expected done within 7000 cycles");
      end
      @(negedge clk);
      check_output("frame_writes", 32'(frame_writes), 32'd1024);
      check_output("done_count", 32'(done_cnt), 32'd1);
      check_output("last_rd_addr", 32'(last_rd_addr), 32'd4095);
      check_output("last_wr_addr", 32'(last_wr_addr), 32'd1023);
      check_output("frame_cycles", 32'(last_wr_cycle - first_rd_cycle + 1), 32'd6144);
      check_output("queue_empty", 32'(q.size()), 32'd0);
   endtask

   initial begin
      bit hit;
      reset = 1'b1;
      start = 1'b0;
      fill_random();
      repeat (3) @(posedge clk);
      #1 start = 1'b1;
      @(negedge clk);
      check_output("rst_busy", 32'(busy), 32'h0);
      check_output("rst_done", 32'(done), 32'h0);
      check_output("rst_crd", 32'(crd), 32'h0);
      check_output("rst_cwr", 32'(cwr), 32'h0);
      check_output("rst_csel", 32'(csel), 32'h0);
      check_output("rst_caddr_rd", 32'(caddr_rd), 32'h0);
      check_output("rst_caddr_wr", 32'(caddr_wr), 32'h0);
      check_output("rst_cdata_wr", 32'(cdata_wr), 32'h0);
      @(posedge clk); #1;
      check_output("rst_over_start", 32'(busy), 32'h0);
      start = 1'b0;
      reset = 1'b0;
      repeat (2) @(posedge clk);

      $display("[TB] frame 1: directed windows plus random data, start re-pulsed while busy");
      set_window(0,    20'h10000, 20'h30000, 20'h20000, 20'h00000, 20'h30000);
      set_window(1,    20'h10000, 20'h24000, 20'h1FFFF, 20'hF0000, 20'h30000);
      set_window(2,    20'h70001, 20'h60000, 20'h70000, 20'h80000, 20'h7FFFF);
      set_window(3,    20'hE8000, 20'hF0000, 20'hFC000, 20'hE0000, 20'h00000);
      set_window(4,    20'h80000, 20'h80000, 20'h80000, 20'h80000, 20'h80000);
      set_window(5,    20'h40000, 20'h40000, 20'hFFFFF, 20'h00000, 20'h40000);
      set_window(6,    20'hE8000, 20'hE8000, 20'hD0001, 20'hC0000, 20'hF0000);
      set_window(33,   20'h24000, 20'h00001, 20'h12345, 20'hFFFFF, 20'h30000);
      set_window(1023, 20'h7FFFF, 20'h00000, 20'h7FFFE, 20'h80001, 20'h7FFFF);
      run_frame(1'b1);

      $display("[TB] frame 2: reset during output 500");
      fill_random();
      clear_frame();
      apply_stimulus();
      hit = 1'b0;
      for (int i = 0; i < 4000 && !hit; i++) begin
         @(negedge clk);
         if (frame_writes == 500) hit = 1'b1;
      end
      if (!hit) begin
         total++;
         bad++;
         $display("[TB] FAIL abort_wait: got %0d writes expected 500", frame_writes);
      end
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      q.delete();
      check_output("abort_busy", 32'(busy), 32'h0);
      check_output("abort_cwr", 32'(cwr), 32'h0);
      repeat (30) @(negedge clk);
      check_output("abort_writes", 32'(frame_writes), 32'd500);
      check_output("abort_done", 32'(done_cnt), 32'd0);

      $display("[TB] frame 3: fresh start after abort");
      fill_random();
      set_window(0, 20'hFFFFF, 20'hFC000, 20'hF8001, 20'hE0000, 20'h00000);
      run_frame(1'b0);

      $display("[TB] test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
